// File: rtl/phivers_inj_mux_pkg.sv
// Shared types and header field layout for the PHIVERS injector multiplexer.
// Imported by the arbiter and the top-level mux.
package PhiversPkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEADER  = 2'd1,
      ST_SIZE    = 2'd2,
      ST_PAYLOAD = 2'd3
   } inj_state_e;

   typedef enum logic {
      MODE_FWD  = 1'b0,
      MODE_DROP = 1'b1
   } inj_mode_e;

   localparam int unsigned HDR_X_MSB = 32'd15;
   localparam int unsigned HDR_X_LSB = 32'd8;
   localparam int unsigned HDR_Y_MSB = 32'd7;
   localparam int unsigned HDR_Y_LSB = 32'd0;

   // A header addresses a real router only if both coordinates fall inside the mesh.
   function automatic logic hdr_in_mesh(input logic [7:0]  x,
                                        input logic [7:0]  y,
                                        input int unsigned n_pe_x,
                                        input int unsigned n_pe_y);
      return (32'(x) < n_pe_x) && (32'(y) < n_pe_y);
   endfunction

endpackage

// File: rtl/phivers_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer,
// wrapping around the channel list.
module phivers_rr_arbiter
   import PhiversPkg::*;
#(
   parameter int N_CH = 2
) (
   input  logic [N_CH-1:0]         req_i,
   input  logic [$clog2(N_CH)-1:0] ptr_i,
   output logic [$clog2(N_CH)-1:0] gnt_idx_o,
   output logic                    valid_o
);

   localparam int          IW     = $clog2(N_CH);
   localparam int unsigned N_CH_U = 32'(N_CH);

   function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p,
                                              input int unsigned   off);
      int unsigned s;
      s = 32'(p) + off;
      if (s >= N_CH_U) begin
         s = s - N_CH_U;
      end else begin
         s = s;
      end
      return IW'(s);
   endfunction

   // Scan channels starting at the pointer and keep the first one that asks.
   always_comb begin
      logic [IW-1:0] cand;
      gnt_idx_o = '0;
      valid_o   = 1'b0;
      cand      = '0;
      for (int i = 0; i < N_CH; i++) begin
         cand = wrap_idx(ptr_i, 32'(i));
         if (!valid_o && req_i[cand]) begin
            gnt_idx_o = cand;
            valid_o   = 1'b1;
         end else begin
            valid_o   = valid_o;
         end
      end
   end

endmodule

// File: rtl/phivers_inj_mux.sv
// Packet-atomic N:1 injector mux toward a Hermes router port; packets with an
// out-of-mesh header are consumed locally and reported on drop_o.
module phivers_inj_mux
   import PhiversPkg::*;
#(
   parameter int N_CH      = 2,
   parameter int FLIT_SIZE = 32,
   parameter int N_PE_X    = 2,
   parameter int N_PE_Y    = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [N_CH-1:0]                src_rx_i,
   input  logic [N_CH-1:0][FLIT_SIZE-1:0] src_data_i,
   output logic [N_CH-1:0]                src_credit_o,
   output logic                           tx_o,
   output logic [FLIT_SIZE-1:0]           data_o,
   input  logic                           credit_i,
   output logic                           drop_o
);

   localparam int          IW       = $clog2(N_CH);
   localparam int unsigned N_PE_X_U = 32'(N_PE_X);
   localparam int unsigned N_PE_Y_U = 32'(N_PE_Y);

   inj_state_e           state_q, state_d;
   inj_mode_e            mode_q,  mode_d;
   logic [IW-1:0]        grant_q, grant_d;
   logic [IW-1:0]        rr_q,    rr_d;
   logic [FLIT_SIZE-1:0] cnt_q,   cnt_d;
   logic                 drop_q,  drop_d;

   logic [IW-1:0]        arb_idx_s;
   logic                 arb_valid_s;
   logic                 sel_rx_s;
   logic [FLIT_SIZE-1:0] sel_data_s;
   inj_mode_e            hdr_mode_s;
   inj_mode_e            act_mode_s;
   logic                 xfer_s;
   logic                 last_s;
   logic                 tx_s;
   logic [FLIT_SIZE-1:0] data_s;
   logic [N_CH-1:0]      credit_s;

   phivers_rr_arbiter #(
      .N_CH (N_CH)
   ) u_arb (
      .req_i     (src_rx_i),
      .ptr_i     (rr_q),
      .gnt_idx_o (arb_idx_s),
      .valid_o   (arb_valid_s)
   );

   assign sel_rx_s   = src_rx_i[grant_q];
   assign sel_data_s = src_data_i[grant_q];
   assign hdr_mode_s = hdr_in_mesh(sel_data_s[HDR_X_MSB:HDR_X_LSB],
                                   sel_data_s[HDR_Y_MSB:HDR_Y_LSB],
                                   N_PE_X_U, N_PE_Y_U) ? MODE_FWD : MODE_DROP;

   // Link steering plus next-state logic; the mode is live from the header
   // flit itself so the header can be forwarded with no added latency.
   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      grant_d  = grant_q;
      rr_d     = rr_q;
      cnt_d    = cnt_q;
      drop_d   = 1'b0;
      tx_s     = 1'b0;
      data_s   = '0;
      credit_s = '0;
      xfer_s   = 1'b0;
      last_s   = 1'b0;
      act_mode_s = (state_q == ST_HEADER) ? hdr_mode_s : mode_q;

      if (state_q != ST_IDLE) begin
         if (act_mode_s == MODE_FWD) begin
            tx_s              = sel_rx_s;
            data_s            = sel_rx_s ? sel_data_s : '0;
            credit_s[grant_q] = credit_i;
            xfer_s            = sel_rx_s & credit_i;
         end else begin
            credit_s[grant_q] = 1'b1;
            xfer_s            = sel_rx_s;
         end
      end else begin
         xfer_s = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (arb_valid_s) begin
               grant_d = arb_idx_s;
               state_d = ST_HEADER;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HEADER: begin
            if (xfer_s) begin
               mode_d  = hdr_mode_s;
               state_d = ST_SIZE;
            end else begin
               state_d = ST_HEADER;
            end
         end
         ST_SIZE: begin
            if (xfer_s) begin
               cnt_d = sel_data_s;
               if (sel_data_s == '0) begin
                  last_s = 1'b1;
               end else begin
                  state_d = ST_PAYLOAD;
               end
            end else begin
               state_d = ST_SIZE;
            end
         end
         ST_PAYLOAD: begin
            if (xfer_s) begin
               cnt_d = cnt_q - FLIT_SIZE'(1);
               if (cnt_q == FLIT_SIZE'(1)) begin
                  last_s = 1'b1;
               end else begin
                  state_d = ST_PAYLOAD;
               end
            end else begin
               state_d = ST_PAYLOAD;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Packet done: release the link and move fairness past this channel.
      if (last_s) begin
         state_d = ST_IDLE;
         rr_d    = (grant_q == IW'(N_CH - 1)) ? '0 : grant_q + IW'(1);
         drop_d  = (mode_q == MODE_DROP);
      end else begin
         drop_d  = 1'b0;
      end
   end

   // State registers; async reset aborts any packet in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_FWD;
         grant_q <= '0;
         rr_q    <= '0;
         cnt_q   <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         drop_q  <= drop_d;
      end
   end

   assign tx_o         = tx_s;
   assign data_o       = data_s;
   assign src_credit_o = credit_s;
   assign drop_o       = drop_q;

endmodule
